eg_update_engine: RTL and testbench

//  Time-multiplexed envelope update stage for the 18 FM slots; sits directly upstream of the envelope memory.
//  Per slot tick: reads the slot's 25-bit EG record (state[24:23], phase[22:0]) and applies key edges and rate.

---
 rtl/eg_update_engine.sv | 160 ++++++++++++++++
 tb/tb_eg_update_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eg_update_engine.sv
// eg_update_engine
//   Time-multiplexed envelope update stage shared by 18 FM slots. Each ce tick
//   reads one slot's 25-bit EG record {state[1:0], phase[22:0]} from the
//   envelope memory, applies key edges and the current state's rate, writes the
//   record back and reports the 7-bit attenuation (phase[22:16]).
//   Pipeline: R (raddr, counter advance) -> U (update, write) -> O (egout).
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   ce                       slot tick, one slot enters the pipe per ce=1
//   key[17:0]                key-on level per slot
//   par_slot                 slot whose ar/dr/sl/rr are expected this cycle
//   ar, dr, rr, sl           rates / sustain level for par_slot
//   raddr / rdata            EG memory read port (rdata valid one cycle later)
//   waddr / wr / wdata       EG memory write port
//   egout, egout_slot,
//   egout_valid              attenuation result, one-cycle valid pulse
module eg_update_engine #(
  parameter int NSLOTS    = 18,
  parameter int INIT_WAIT = 18
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [17:0] key,
  output logic [4:0]  par_slot,
  input  logic [3:0]  ar,
  input  logic [3:0]  dr,
  input  logic [3:0]  rr,
  input  logic [3:0]  sl,
  output logic [4:0]  raddr,
  input  logic [24:0] rdata,
  output logic [4:0]  waddr,
  output logic        wr,
  output logic [24:0] wdata,
  output logic [6:0]  egout,
  output logic [4:0]  egout_slot,
  output logic        egout_valid
);

  localparam logic [1:0] ST_ATTACK  = 2'd0;
  localparam logic [1:0] ST_DECAY   = 2'd1;
  localparam logic [1:0] ST_SUSTAIN = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam int IW_W = $clog2(INIT_WAIT + 1);

  logic [4:0]      slot_q, slot_d;
  logic            u_valid_q, u_valid_d;
  logic [4:0]      u_slot_q, u_slot_d;
  logic [17:0]     key_prev_q, key_prev_d;
  logic [IW_W-1:0] init_cnt_q, init_cnt_d;
  logic [6:0]      egout_q, egout_d;
  logic [4:0]      egout_slot_q, egout_slot_d;
  logic            egout_valid_q, egout_valid_d;

  logic            init_done;
  logic            key_now, key_old;
  logic [1:0]      cur_st, nxt_st;
  logic [22:0]     cur_ph, nxt_ph;
  logic [3:0]      rate;
  logic [22:0]     inc, ph_dn, ph_up;
  logic [23:0]     ph_sum;

  assign init_done = (init_cnt_q == IW_W'(INIT_WAIT));

  // Record update for the slot sitting in stage U
  always_comb begin
    cur_st  = rdata[24:23];
    cur_ph  = rdata[22:0];
    key_now = key[u_slot_q];
    key_old = key_prev_q[u_slot_q];
    case (cur_st)
      ST_ATTACK:  rate = ar;
      ST_DECAY:   rate = dr;
      ST_RELEASE: rate = rr;
      default:    rate = 4'd0;
    endcase
    inc    = 23'd1 << rate;
    ph_sum = {1'b0, cur_ph} + {1'b0, inc};
    ph_up  = ph_sum[23] ? '1 : ph_sum[22:0];
    ph_dn  = (cur_ph <= inc) ? '0 : cur_ph - inc;
    nxt_st = cur_st;
    nxt_ph = cur_ph;
    // Key edges take priority over any rate step in the same visit
    if (key_now && !key_old) begin
      nxt_st = ST_ATTACK;
    end else if (!key_now && key_old) begin
      nxt_st = ST_RELEASE;
    end else if (rate != 4'd0) begin
      case (cur_st)
        ST_ATTACK: begin
          if (rate == 4'd15) begin
            nxt_ph = '0;
            nxt_st = ST_DECAY;
          end else begin
            nxt_ph = ph_dn;
            if (ph_dn == '0) nxt_st = ST_DECAY;
          end
        end
        ST_DECAY: begin
          nxt_ph = ph_up;
          if (ph_up[22:19] >= sl) nxt_st = ST_SUSTAIN;
        end
        ST_RELEASE: nxt_ph = ph_up;
        default: ;
      endcase
    end
  end

  always_comb begin
    slot_d        = slot_q;
    u_valid_d     = ce;
    u_slot_d      = slot_q;
    key_prev_d    = key_prev_q;
    init_cnt_d    = init_cnt_q;
    egout_d       = egout_q;
    egout_slot_d  = egout_slot_q;
    egout_valid_d = u_valid_q;
    if (ce) slot_d = (slot_q == 5'(NSLOTS - 1)) ? '0 : slot_q + 5'd1;
    if (!init_done) init_cnt_d = init_cnt_q + 1'b1;
    if (u_valid_q) begin
      key_prev_d[u_slot_q] = key_now;
      egout_d              = nxt_ph[22:16];
      egout_slot_d         = u_slot_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q        <= '0;
      u_valid_q     <= 1'b0;
      u_slot_q      <= '0;
      key_prev_q    <= '0;
      init_cnt_q    <= '0;
      egout_q       <= '0;
      egout_slot_q  <= '0;
      egout_valid_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      u_valid_q     <= u_valid_d;
      u_slot_q      <= u_slot_d;
      key_prev_q    <= key_prev_d;
      init_cnt_q    <= init_cnt_d;
      egout_q       <= egout_d;
      egout_slot_q  <= egout_slot_d;
      egout_valid_q <= egout_valid_d;
    end
  end

  assign raddr       = slot_q;
  assign par_slot    = u_slot_q;
  assign waddr       = u_slot_q;
  // Memory is self-initialising for INIT_WAIT cycles; suppress writes until then
  assign wr          = u_valid_q && init_done;
  assign wdata       = u_valid_q ? {nxt_st, nxt_ph} : '0;
  assign egout       = egout_q;
  assign egout_slot  = egout_slot_q;
  assign egout_valid = egout_valid_q;

endmodule

// File: tb/tb_eg_update_engine.sv
module tb_eg_update_engine;
  localparam int NS = 18;
  localparam int IW = 18;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic [17:0] key = '0;
  logic [4:0]  par_slot, raddr, waddr, egout_slot;
  logic [3:0]  ar, dr, rr, sl;
  logic [24:0] rdata, wdata;
  logic        wr, egout_valid;
  logic [6:0]  egout;

  logic [3:0]  ar_t[NS], dr_t[NS], rr_t[NS], sl_t[NS];
  logic [24:0] mem[NS];
  logic [24:0] poke_val[NS];
  logic        poke_req = 1'b1;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [24:0] m_rec[NS];
  bit          m_kp[NS];
  int          m_slot, m_uslot, m_init;
  bit          m_uv;
  logic [24:0] cap_w[NS];
  logic [6:0]  cap_e[NS];
  logic [17:0] kv;

  typedef struct {
    logic [1:0]  st;
    logic [22:0] ph;
    logic        k;
    logic [3:0]  ar, dr, sl, rr;
    logic [1:0]  est;
    logic [22:0] eph;
  } vec_t;
  vec_t tv[12];

  always #5 clk = ~clk;

  assign ar = (int'(par_slot) < NS) ? ar_t[par_slot] : '0;
  assign dr = (int'(par_slot) < NS) ? dr_t[par_slot] : '0;
  assign rr = (int'(par_slot) < NS) ? rr_t[par_slot] : '0;
  assign sl = (int'(par_slot) < NS) ? sl_t[par_slot] : '0;

  always @(posedge clk) begin
    rdata <= (int'(raddr) < NS) ? mem[raddr] : '1;
    if (poke_req) begin
      for (int i = 0; i < NS; i++) mem[i] <= poke_val[i];
    end else if (wr && int'(waddr) < NS) begin
      mem[waddr] <= wdata;
    end
  end

  eg_update_engine #(.NSLOTS(NS), .INIT_WAIT(IW)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .key(key), .par_slot(par_slot),
    .ar(ar), .dr(dr), .rr(rr), .sl(sl), .raddr(raddr), .rdata(rdata),
    .waddr(waddr), .wr(wr), .wdata(wdata), .egout(egout),
    .egout_slot(egout_slot), .egout_valid(egout_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Envelope rules in plain integer arithmetic
  function automatic logic [24:0] ref_next(int s, logic [17:0] k);
    int st, ph, r, stepv;
    bit kn, kp;
    st = int'(m_rec[s][24:23]);
    ph = int'(m_rec[s][22:0]);
    kn = k[s];
    kp = m_kp[s];
    if (kn && !kp) return {2'd0, m_rec[s][22:0]};
    if (!kn && kp) return {2'd3, m_rec[s][22:0]};
    case (st)
      0: r = int'(ar_t[s]);
      1: r = int'(dr_t[s]);
      3: r = int'(rr_t[s]);
      default: r = 0;
    endcase
    if (r == 0) return m_rec[s];
    stepv = 1 << r;
    if (st == 0) begin
      if (r == 15 || ph <= stepv) return {2'd1, 23'd0};
      return {2'd0, 23'(ph - stepv)};
    end
    ph = ph + stepv;
    if (ph > 'h7FFFFF) ph = 'h7FFFFF;
    if (st == 1) return {((ph >> 19) >= int'(sl_t[s])) ? 2'd2 : 2'd1, 23'(ph)};
    return {2'd3, 23'(ph)};
  endfunction

  task automatic step(input logic ce_i, input logic [17:0] key_i, input bit poke = 1'b0);
    logic [24:0] nrec;
    bit          exp_wr, exp_egv;
    int          exp_slot;
    logic [6:0]  exp_eg;
    @(negedge clk);
    ce = ce_i;
    key = key_i;
    poke_req = poke;
    #1;
    chk("raddr", 32'(raddr), 32'(m_slot));
    exp_wr = m_uv && (m_init >= IW);
    chk("wr", 32'(wr), 32'(exp_wr));
    exp_egv = m_uv;
    exp_slot = m_uslot;
    exp_eg = '0;
    if (m_uv) begin
      nrec = ref_next(m_uslot, key_i);
      chk("par_slot", 32'(par_slot), 32'(m_uslot));
      exp_eg = nrec[22:16];
      if (exp_wr) begin
        chk("waddr", 32'(waddr), 32'(m_uslot));
        chk("wdata", 32'(wdata), 32'(nrec));
        cap_w[m_uslot] = wdata;
        m_rec[m_uslot] = nrec;
      end
      m_kp[m_uslot] = key_i[m_uslot];
    end
    if (poke) for (int i = 0; i < NS; i++) m_rec[i] = poke_val[i];
    m_uv = ce_i;
    m_uslot = m_slot;
    if (ce_i) m_slot = (m_slot == NS - 1) ? 0 : m_slot + 1;
    if (m_init < IW) m_init++;
    @(posedge clk);
    #1;
    poke_req = 1'b0;
    chk("egout_valid", 32'(egout_valid), 32'(exp_egv));
    if (exp_egv) begin
      chk("egout", 32'(egout), 32'(exp_eg));
      chk("egout_slot", 32'(egout_slot), 32'(exp_slot));
      cap_e[exp_slot] = egout;
    end
  endtask

  task automatic round(input logic [17:0] k);
    repeat (NS) step(1'b1, k);
  endtask

  task automatic model_reset();
    m_uv = 1'b0;
    m_slot = 0;
    m_uslot = 0;
    m_init = 0;
    for (int i = 0; i < NS; i++) m_kp[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ce = 1'b0;
    #1;
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_egout_valid", 32'(egout_valid), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_egout", 32'(egout), 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic clear_rates();
    for (int i = 0; i < NS; i++) begin
      ar_t[i] = '0; dr_t[i] = '0; rr_t[i] = '0; sl_t[i] = '0;
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      poke_val[i] = '1;
      m_rec[i] = '1;
      cap_w[i] = '0;
      cap_e[i] = '0;
    end
    clear_rates();
    model_reset();
    tv[0]  = '{2'd0, 23'h100000, 1'b1, 4'd4,  4'd0,  4'd0,  4'd0,  2'd0, 23'h0FFFF0};
    tv[1]  = '{2'd0, 23'h000008, 1'b1, 4'd5,  4'd0,  4'd0,  4'd0,  2'd1, 23'h000000};
    tv[2]  = '{2'd0, 23'h7FFFFF, 1'b1, 4'd15, 4'd0,  4'd0,  4'd0,  2'd1, 23'h000000};
    tv[3]  = '{2'd0, 23'h123456, 1'b1, 4'd0,  4'd9,  4'd0,  4'd9,  2'd0, 23'h123456};
    tv[4]  = '{2'd1, 23'h000000, 1'b1, 4'd0,  4'd15, 4'd4,  4'd0,  2'd1, 23'h008000};
    tv[5]  = '{2'd1, 23'h1F8000, 1'b1, 4'd0,  4'd15, 4'd4,  4'd0,  2'd2, 23'h200000};
    tv[6]  = '{2'd1, 23'h7FFFF0, 1'b1, 4'd0,  4'd14, 4'd15, 4'd0,  2'd2, 23'h7FFFFF};
    tv[7]  = '{2'd1, 23'h100000, 1'b1, 4'd0,  4'd3,  4'd0,  4'd0,  2'd2, 23'h100008};
    tv[8]  = '{2'd2, 23'h300000, 1'b1, 4'd5,  4'd5,  4'd0,  4'd5,  2'd2, 23'h300000};
    tv[9]  = '{2'd3, 23'h7FFF00, 1'b0, 4'd0,  4'd0,  4'd0,  4'd15, 2'd3, 23'h7FFFFF};
    tv[10] = '{2'd3, 23'h000100, 1'b0, 4'd0,  4'd0,  4'd0,  4'd1,  2'd3, 23'h000102};
    tv[11] = '{2'd3, 23'h000200, 1'b0, 4'd0,  4'd0,  4'd0,  4'd0,  2'd3, 23'h000200};

    // power-up reset; memory loaded with all ones meanwhile
    repeat (3) @(posedge clk);
    #1;
    chk("por_wr", 32'(wr), 32'd0);
    chk("por_egout_valid", 32'(egout_valid), 32'd0);
    chk("por_par_slot", 32'(par_slot), 32'd0);
    #1;
    poke_req = 1'b0;
    reset_n = 1'b1;

    // init guard, silent slots, slot order
    round('0);
    round('0);
    chk("init_egout_s17", 32'(cap_e[17]), 32'd127);

    // directed record-update vectors on slots 0..11
    kv = '0;
    for (int i = 0; i < 12; i++) begin
      kv[i] = tv[i].k;
      ar_t[i] = tv[i].ar; dr_t[i] = tv[i].dr; sl_t[i] = tv[i].sl; rr_t[i] = tv[i].rr;
      poke_val[i] = {tv[i].st, tv[i].ph};
    end
    round(kv);
    step(1'b0, kv, 1'b1);
    round(kv);
    step(1'b0, kv);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("vec%0d_wdata", i), 32'(cap_w[i]), 32'({tv[i].est, tv[i].eph}));
      chk($sformatf("vec%0d_egout", i), 32'(cap_e[i]), 32'(tv[i].eph[22:16]));
    end

    // key-on with ar=15: ATTACK on the edge visit, DECAY/phase 0 on the next
    clear_rates();
    for (int i = 0; i < NS; i++) poke_val[i] = '1;
    round('0);
    step(1'b0, '0, 1'b1);
    ar_t[3] = 4'd15;
    kv = 18'h00008;
    round(kv);
    chk("keyon_edge_wdata", 32'(cap_w[3]), 32'h007FFFFF);
    round(kv);
    chk("keyon_ar15_egout", 32'(cap_e[3]), 32'd0);
    chk("keyon_ar15_wdata", 32'(cap_w[3]), 32'h00800000);

    // decay to sustain (slot 5 sl=4, slot 7 sl=1), then release of slot 7
    ar_t[5] = 4'd15; dr_t[5] = 4'd15; sl_t[5] = 4'd4;
    ar_t[7] = 4'd15; dr_t[7] = 4'd15; sl_t[7] = 4'd1; rr_t[7] = 4'd15;
    kv = 18'h000A8;
    repeat (3) round(kv);
    chk("decay_first_step", 32'(cap_w[5]), 32'h00808000);
    repeat (66) round(kv);
    chk("decay_sustain_s5", 32'(cap_w[5]), 32'h01200000);
    chk("decay_sustain_s7", 32'(cap_w[7]), 32'h01080000);
    kv = 18'h00028;
    round(kv);
    chk("release_edge_s7", 32'(cap_w[7]), 32'h01880000);
    repeat (245) round(kv);
    chk("release_sat_s7", 32'(cap_w[7]), 32'h01FFFFFF);
    chk("release_egout_s7", 32'(cap_e[7]), 32'd127);
    step(1'b0, kv);

    // ce gaps
    step(1'b1, kv); step(1'b0, kv); step(1'b0, kv); step(1'b1, kv);
    step(1'b0, kv); step(1'b0, kv);

    // randomized traffic against the model
    for (int n = 0; n < 900; n++) begin
      if (n % 100 == 0) begin
        for (int i = 0; i < NS; i++) begin
          ar_t[i] = 4'($urandom_range(0, 15)); dr_t[i] = 4'($urandom_range(0, 15));
          rr_t[i] = 4'($urandom_range(0, 15)); sl_t[i] = 4'($urandom_range(0, 15));
        end
      end
      if ($urandom_range(0, 7) == 0) kv[$urandom_range(0, NS - 1)] ^= 1'b1;
      step(1'($urandom_range(0, 3) != 0), kv);
    end

    // reset mid-round while a write is in flight
    repeat (5) step(1'b1, kv);
    do_reset();
    repeat (40) step(1'b1, kv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
